// File: rtl/line_peak_finder.sv
`default_nettype none
// ============================================================================
// line_peak_finder
//   Buffers one sensor line while tracking its peak, then replays it in order.
//   Revision: 1.0
// ============================================================================
module line_peak_finder #(
  parameter int NUM_PIX = 512,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              line_start,
  output logic              start,
  output logic [ADDR_W-1:0] max_pos,
  output logic [DATA_W-1:0] max_value,
  output logic              data_valid,
  output logic [ADDR_W-1:0] adress,
  output logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              overrun
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_CAPTURE = 3'd1;
  localparam logic [2:0] c_START   = 3'd2;
  localparam logic [2:0] c_REPLAY  = 3'd3;
  localparam logic [2:0] c_TAIL    = 3'd4;

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NUM_PIX - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W:0]   r_rd_cnt;
  logic [DATA_W-1:0] r_max_value;
  logic [ADDR_W-1:0] r_max_pos;
  logic              r_data_valid;
  logic [ADDR_W-1:0] r_adress;
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_mem [NUM_PIX];

  logic              w_line_go;
  logic              w_accept_first;
  logic              w_accept_next;
  logic              w_we;
  logic              w_last;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_start;
  logic              w_busy;

  assign w_line_go      = pix_valid & line_start;
  assign w_accept_first = w_line_go & ((r_state == c_IDLE) | (r_state == c_CAPTURE));
  assign w_accept_next  = pix_valid & ~line_start & (r_state == c_CAPTURE);
  assign w_we           = w_accept_first | w_accept_next;
  assign w_last         = w_accept_next & (r_cnt == c_LAST);
  // The top bit of the replay counter marks that every address has been issued.
  assign w_rd_en        = (r_state == c_REPLAY) & ~r_rd_cnt[ADDR_W];
  // Capture and replay never overlap, so one shared RAM address suffices.
  assign w_ram_addr     = w_rd_en        ? r_rd_cnt[ADDR_W-1:0] :
                          w_accept_first ? '0 : r_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (w_line_go) w_next = c_CAPTURE;
      c_CAPTURE: if (w_last) w_next = c_START;
      c_START:   w_next = c_REPLAY;
      c_REPLAY:  if (r_rd_cnt[ADDR_W]) w_next = c_TAIL;
      c_TAIL:    w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_start = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      c_START:  begin w_start = 1'b1; w_busy = 1'b1; end
      c_REPLAY: w_busy = 1'b1;
      c_TAIL:   w_busy = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_max_value <= '0;
      r_max_pos   <= '0;
    end else if (w_accept_first) begin
      r_cnt       <= ADDR_W'(1);
      r_max_value <= pix_data;
      r_max_pos   <= '0;
    end else if (w_accept_next) begin
      r_cnt <= r_cnt + 1'b1;
      if (pix_data > r_max_value) begin
        r_max_value <= pix_data;
        r_max_pos   <= r_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                  r_rd_cnt <= '0;
    else if (r_state == c_START) r_rd_cnt <= '0;
    else if (w_rd_en)            r_rd_cnt <= r_rd_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_valid <= 1'b0;
      r_adress     <= '0;
    end else begin
      r_data_valid <= w_rd_en;
      if (w_rd_en) r_adress <= r_rd_cnt[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_ram_addr] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       r_ram_q <= '0;
    else if (w_rd_en) r_ram_q <= r_mem[w_ram_addr];
  end

  assign start      = w_start;
  assign busy       = w_busy;
  assign overrun    = w_busy & w_line_go;
  assign max_pos    = r_max_pos;
  assign max_value  = r_max_value;
  assign data_valid = r_data_valid;
  assign adress     = r_adress;
  assign value      = r_ram_q;

endmodule
`default_nettype wire

// File: tb/tb_line_peak_finder.sv
`default_nettype none
// ============================================================================
// tb_line_peak_finder
//   Directed line captures with hand-derived peaks and cycle-exact replay checks.
//   Revision: 1.0
// ============================================================================
module tb_line_peak_finder;
  localparam int NUM_PIX = 512;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              line_start;
  logic              start;
  logic [ADDR_W-1:0] max_pos;
  logic [DATA_W-1:0] max_value;
  logic              data_valid;
  logic [ADDR_W-1:0] adress;
  logic [DATA_W-1:0] value;
  logic              busy;
  logic              overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int ovr_cnt  = 0;
  int line_in [NUM_PIX];

  line_peak_finder #(.NUM_PIX(NUM_PIX), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data),
    .line_start(line_start), .start(start), .max_pos(max_pos),
    .max_value(max_value), .data_valid(data_valid), .adress(adress),
    .value(value), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (overrun === 1'b1) ovr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start"}, start, 0);
    check({tag, "_max_pos"}, max_pos, 0);
    check({tag, "_max_value"}, max_value, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_adress"}, adress, 0);
    check({tag, "_value"}, value, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  // Returns in cycle T+1, one cycle after the last pixel was sampled.
  task automatic send_line(input bit gaps);
    for (int k = 0; k < NUM_PIX; k++) begin
      pix_valid  = 1'b1;
      line_start = (k == 0);
      pix_data   = line_in[k][DATA_W-1:0];
      step();
      if (gaps && k != NUM_PIX - 1) begin
        pix_valid  = 1'b0;
        line_start = 1'b0;
        step();
      end
    end
    pix_valid  = 1'b0;
    line_start = 1'b0;
  endtask

  // Walks cycles T+1..T+516; cycle numbers are relative to T.
  task automatic run_replay(input int exp_pos, input int exp_max, input int ovr_at, input int rst_at);
    check("start_T1", start, 1);
    check("busy_T1", busy, 1);
    check("max_pos", max_pos, exp_pos);
    check("max_value", max_value, exp_max);
    for (int c = 2; c <= 516; c++) begin
      step();
      if (c == 2) begin
        check("start_T2", start, 0);
        check("dv_T2", data_valid, 0);
      end else if (c <= 514) begin
        check("dv_replay", data_valid, 1);
        check("adress_replay", adress, c - 3);
        check("value_replay", value, line_in[c - 3]);
        check("max_stable", max_value, exp_max);
      end else if (c == 515) begin
        check("dv_tail", data_valid, 0);
        check("adress_tail", adress, NUM_PIX - 1);
        check("busy_tail", busy, 1);
      end else begin
        check("busy_idle", busy, 0);
        check("dv_idle", data_valid, 0);
      end
      if (c == ovr_at) begin
        pix_valid  = 1'b1;
        line_start = 1'b1;
        pix_data   = 10'd1023;
        #1;
        check("overrun_pulse", overrun, 1);
      end else if (c == ovr_at + 1) begin
        pix_valid  = 1'b0;
        line_start = 1'b0;
        #1;
        check("overrun_clear", overrun, 0);
      end
      if (c == rst_at) begin
        rst_n = 1'b0;
        step();
        check_idle_outputs("mid_reset");
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    pix_valid  = 1'b0;
    line_start = 1'b0;
    pix_data   = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    // Pixels without line_start in IDLE must be ignored.
    pix_valid = 1'b1;
    pix_data  = 10'd1023;
    repeat (4) step();
    pix_valid = 1'b0;
    check("idle_ignore_busy", busy, 0);
    step();

    for (int k = 0; k < NUM_PIX; k++) line_in[k] = k & 1023;
    send_line(1'b0);
    run_replay(511, 511, 0, 0);

    for (int k = 0; k < NUM_PIX; k++) line_in[k] = 10;
    line_in[100] = 900;
    line_in[300] = 900;
    send_line(1'b1);
    run_replay(100, 900, 0, 0);

    // Abandoned partial line with a higher peak, then a restart.
    for (int k = 0; k < 200; k++) begin
      pix_valid  = 1'b1;
      line_start = (k == 0);
      pix_data   = (k == 150) ? 10'd1000 : 10'(k);
      step();
    end
    for (int k = 0; k < NUM_PIX; k++) line_in[k] = 5;
    line_in[50] = 700;
    send_line(1'b0);
    check("restart_no_overrun", ovr_cnt, 0);
    run_replay(50, 700, 0, 0);

    // Peak of (7k mod 1024) over k<512 is 1022 at k=146.
    for (int k = 0; k < NUM_PIX; k++) line_in[k] = (k * 7) & 1023;
    send_line(1'b0);
    run_replay(146, 1022, 100, 0);
    check("overrun_count", ovr_cnt, 1);

    // Peak of (3k mod 1024) is 1023 at k=341.
    for (int k = 0; k < NUM_PIX; k++) line_in[k] = (k * 3) & 1023;
    send_line(1'b0);
    run_replay(341, 1023, 0, 200);
    step();
    check("post_reset_busy", busy, 0);
    check("post_reset_dv", data_valid, 0);

    for (int k = 0; k < NUM_PIX; k++) line_in[k] = 0;
    send_line(1'b0);
    run_replay(0, 0, 0, 0);
    check("final_overrun_count", ovr_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
`default_nettype wire
